// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one pipelined main memory between I-cache fills and D-cache fills/stores
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_req, i_addr         I-side block fill request (held until i_done) and miss byte address
//   i_grant               I-side currently owns the memory
//   i_data_valid, i_data  returned fill word for the I-side
//   i_word, i_done        word index within the block; pulse on the final word
//   d_req, d_wr           D-side request (held until d_done); 1 = single-word store, 0 = block fill
//   d_addr, d_wdata       D-side byte address and store data
//   d_grant .. d_done     D-side equivalents of the I-side outputs
//   mem_enable, mem_wr    memory access strobe and write qualifier
//   mem_addr, mem_wdata   word-aligned byte address and write data
//   mem_data_in/valid     read data returning in issue order

module mem_arbiter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_req,
  input  logic [15:0]                    i_addr,
  output logic                           i_grant,
  output logic                           i_data_valid,
  output logic [15:0]                    i_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] i_word,
  output logic                           i_done,
  input  logic                           d_req,
  input  logic                           d_wr,
  input  logic [15:0]                    d_addr,
  input  logic [15:0]                    d_wdata,
  output logic                           d_grant,
  output logic                           d_data_valid,
  output logic [15:0]                    d_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] d_word,
  output logic                           d_done,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_data_in,
  input  logic                           mem_data_valid
);

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam logic [WW:0]   NWORDS    = (WW+1)'(BLOCK_WORDS);
  localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);
  // Clears the byte-offset bit plus the word-index bits.
  localparam logic [15:0]   BASE_MASK = ~16'((2 * BLOCK_WORDS) - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t          state_q, state_d;
  logic            owner_q;       // 1 = D-side, 0 = I-side
  logic            last_owner_q;  // same encoding
  logic [15:0]     base_q;
  logic [WW:0]     issue_cnt_q;
  logic [WW-1:0]   recv_cnt_q;

  logic pick_d, pick_i, win, issue_now, rx_now, rx_last;

  // Arbitration: a lone requester wins; on a tie the side that did not
  // own the memory last time wins.
  assign pick_d = d_req && (!i_req || !last_owner_q);
  assign pick_i = i_req && !pick_d;
  assign win    = (state_q == IDLE) && (pick_d || pick_i);

  assign issue_now = (state_q == FILL) && (issue_cnt_q < NWORDS);
  // Responses outside FILL are stale (e.g. in flight across a reset) and dropped.
  assign rx_now    = (state_q == FILL) && mem_data_valid;
  assign rx_last   = rx_now && (recv_cnt_q == LAST_WORD);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_d && d_wr)       state_d = WRITE;
        else if (pick_d || pick_i) state_d = FILL;
      end
      FILL:    if (rx_last) state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      base_q       <= 16'h0000;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (win) begin
        owner_q      <= pick_d;
        last_owner_q <= pick_d;
        base_q       <= (pick_d ? d_addr : i_addr) & BASE_MASK;
        issue_cnt_q  <= '0;
        recv_cnt_q   <= '0;
      end else begin
        if (issue_now) issue_cnt_q <= issue_cnt_q + 1'b1;
        if (rx_now)    recv_cnt_q  <= recv_cnt_q + 1'b1;
      end
    end
  end

  // Outputs are gated to zero whenever not meaningful, so an asynchronous
  // reset (which forces IDLE) clears every output immediately.
  always_comb begin
    i_grant      = 1'b0;
    i_data_valid = 1'b0;
    i_data       = 16'h0000;
    i_word       = '0;
    i_done       = 1'b0;
    d_grant      = 1'b0;
    d_data_valid = 1'b0;
    d_data       = 16'h0000;
    d_word       = '0;
    d_done       = 1'b0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;

    if (state_q != IDLE) begin
      i_grant = !owner_q;
      d_grant = owner_q;
    end

    if (rx_now) begin
      if (owner_q) begin
        d_data_valid = 1'b1;
        d_data       = mem_data_in;
        d_word       = recv_cnt_q;
        d_done       = rx_last;
      end else begin
        i_data_valid = 1'b1;
        i_data       = mem_data_in;
        i_word       = recv_cnt_q;
        i_done       = rx_last;
      end
    end

    if (issue_now) begin
      mem_enable = 1'b1;
      mem_addr   = base_q + 16'({issue_cnt_q, 1'b0});
    end else if (state_q == WRITE) begin
      mem_enable = 1'b1;
      mem_wr     = 1'b1;
      mem_addr   = d_addr & 16'hFFFE;
      mem_wdata  = d_wdata;
      d_done     = 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-programmable memory model

module tb_mem_arbiter;

  localparam int BW = 8;
  localparam int WW = $clog2(BW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [15:0]   i_addr = 16'h0;
  logic          i_grant, i_data_valid, i_done;
  logic [15:0]   i_data;
  logic [WW-1:0] i_word;
  logic          d_req = 1'b0;
  logic          d_wr = 1'b0;
  logic [15:0]   d_addr = 16'h0;
  logic [15:0]   d_wdata = 16'h0;
  logic          d_grant, d_data_valid, d_done;
  logic [15:0]   d_data;
  logic [WW-1:0] d_word;
  logic          mem_enable, mem_wr;
  logic [15:0]   mem_addr, mem_wdata;
  logic [15:0]   mem_data_in;
  logic          mem_data_valid;

  always #5 clk = ~clk;

  mem_arbiter #(.BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid),
    .i_data(i_data), .i_word(i_word), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_grant(d_grant),
    .d_data_valid(d_data_valid), .d_data(d_data), .d_word(d_word), .d_done(d_done),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid)
  );

  typedef struct {bit is_d; bit wr; logic [15:0] addr; logic [15:0] wd;} txn_t;
  typedef struct {bit is_d; int word; logic [15:0] data; bit last;} exp_t;
  typedef struct {bit wr; logic [15:0] addr; logic [15:0] wd;} iss_t;
  typedef struct {int due; logic [15:0] data;} mr_t;

  exp_t exp_q[$];
  iss_t iss_q[$];
  mr_t  mq[$];
  txn_t i_list[$];
  txn_t d_list[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, lat = 4, mv_cnt = 0, n_rx = 0;
  logic        mv_due = 1'b0, stray = 1'b0;
  logic [15:0] mv_data = 16'h0;
  bit last_m = 1'b0;  // model of last owner, 1 = D
  int i_start, i_gnt, i_dn, d_start, d_gnt, d_dn;

  assign mem_data_valid = mv_due | stray;
  assign mem_data_in    = mv_due ? mv_data : 16'hDEAD;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: reads sampled mid-cycle, data returned lat cycles later in order.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    mv_due  = (mq.size() > 0) && (mq[0].due == cyc);
    mv_data = mv_due ? mq[0].data : 16'h0;
    @(negedge clk);
    if (mv_due) begin
      mq.delete(0);
      mv_cnt++;
    end
    if (mem_enable && !mem_wr) mq.push_back('{cyc + lat, memf(mem_addr)});
  end

  // Monitor: pops expectations whenever the DUT presents data or an access.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (i_grant && d_grant) chk("grant_exclusive", 1, 0);
      if (i_data_valid && d_data_valid) chk("single_data_valid", 1, 0);
      if (i_data_valid || d_data_valid) begin
        bit dv_d;
        dv_d = d_data_valid;
        if (exp_q.size() == 0) chk("unexpected_data", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          n_rx++;
          chk("data_owner", dv_d, e.is_d);
          chk("data_word", dv_d ? d_word : i_word, e.word);
          chk("data_value", dv_d ? d_data : i_data, e.data);
          chk("done_flag", dv_d ? d_done : i_done, e.last);
          chk("other_done", dv_d ? i_done : d_done, 0);
        end
      end else if (i_done || d_done || (mem_enable && mem_wr)) begin
        chk("done_no_data", {i_done, d_done}, {1'b0, mem_enable && mem_wr});
      end
      if (mem_enable) begin
        if (iss_q.size() == 0) chk("unexpected_issue", mem_addr, 16'hFFFF);
        else begin
          iss_t s;
          s = iss_q.pop_front();
          chk("issue_wr", mem_wr, s.wr);
          chk("issue_addr", mem_addr, s.addr);
          if (s.wr) begin
            chk("issue_wdata", mem_wdata, s.wd);
            chk("store_grant", d_grant, 1);
          end
        end
      end
    end
  end

  task automatic push_exp(input txn_t t);
    logic [15:0] base;
    if (t.wr) iss_q.push_back('{1'b1, t.addr & 16'hFFFE, t.wd});
    else begin
      base = t.addr & ~16'(2 * BW - 1);
      for (int w = 0; w < BW; w++) begin
        iss_q.push_back('{1'b0, base + 16'(2 * w), 16'h0});
        exp_q.push_back('{t.is_d, w, memf(base + 16'(2 * w)), (w == BW - 1)});
      end
    end
  endtask

  task automatic side_run(input txn_t t);
    int st, g, dn;
    g = -1;
    dn = -1;
    if (t.is_d) begin
      d_wr = t.wr; d_addr = t.addr; d_wdata = t.wd; d_req = 1'b1;
    end else begin
      i_addr = t.addr; i_req = 1'b1;
    end
    st = cyc;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (g < 0 && (t.is_d ? d_grant : i_grant)) g = cyc;
      if (t.is_d ? d_done : i_done) begin
        dn = cyc;
        chk("grant_at_done", t.is_d ? d_grant : i_grant, 1);
        break;
      end
    end
    if (dn < 0) chk("done_timeout", 0, 1);
    if (t.is_d) begin
      d_req = 1'b0; d_wr = 1'b0;
      d_start = st; d_gnt = g; d_dn = dn;
    end else begin
      i_req = 1'b0;
      i_start = st; i_gnt = g; i_dn = dn;
    end
  endtask

  // Reference order: whenever both sides still have work, the side that was
  // not served last wins; otherwise the side with work wins.
  task automatic run_round();
    txn_t iq[$];
    txn_t dq[$];
    bit w;
    iq = i_list;
    dq = d_list;
    while (iq.size() > 0 || dq.size() > 0) begin
      if (iq.size() > 0 && dq.size() > 0) w = !last_m;
      else w = (dq.size() > 0);
      if (w) push_exp(dq.pop_front());
      else   push_exp(iq.pop_front());
      last_m = w;
    end
    repeat (2) @(negedge clk);
    fork
      begin foreach (i_list[k]) side_run(i_list[k]); end
      begin foreach (d_list[k]) side_run(d_list[k]); end
    join
    i_list.delete();
    d_list.delete();
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_i"}, {i_grant, i_data_valid, i_data, i_word, i_done}, 0);
    chk({name, "_d"}, {d_grant, d_data_valid, d_data, d_word, d_done}, 0);
    chk({name, "_mem"}, {mem_enable, mem_wr, mem_addr, mem_wdata}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    #1;
    chk_zero("reset_outputs");
    exp_q.delete();
    iss_q.delete();
    last_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int rx0, mv0, st, ni, nd;
    bit single_wr;
    txn_t t;

    #2;
    chk_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // I-side fill alone, latency 4
    lat = 4;
    i_list.push_back('{1'b0, 1'b0, 16'h1236, 16'h0});
    run_round();
    chk("ifill_grant_lat", i_gnt - i_start, 1);
    chk("ifill_done_lat", i_dn - i_start, BW + 4);

    // Tie right after reset: D wins, I granted two cycles after d_done
    do_reset();
    d_list.push_back('{1'b1, 1'b0, 16'h4000, 16'h0});
    i_list.push_back('{1'b0, 1'b0, 16'h5000, 16'h0});
    run_round();
    chk("tie_gap", i_gnt - d_dn, 2);

    // Round-robin with both sides continuously requesting
    i_list.push_back('{1'b0, 1'b0, 16'h6100, 16'h0});
    i_list.push_back('{1'b0, 1'b0, 16'h6200, 16'h0});
    d_list.push_back('{1'b1, 1'b0, 16'h7100, 16'h0});
    d_list.push_back('{1'b1, 1'b0, 16'h7200, 16'h0});
    run_round();

    // Store with a stray memory valid in the write cycle
    push_exp('{1'b1, 1'b1, 16'h2003, 16'hBEEF});
    last_m = 1'b1;
    repeat (2) @(negedge clk);
    d_wr = 1'b1; d_addr = 16'h2003; d_wdata = 16'hBEEF; d_req = 1'b1;
    st = cyc;
    @(posedge clk);
    #1 stray = 1'b1;
    @(negedge clk);
    chk("store_done", d_done, 1);
    chk("store_no_data", d_data_valid, 0);
    chk("store_cycle", cyc - st, 1);
    d_req = 1'b0; d_wr = 1'b0;
    @(posedge clk);
    #1 stray = 1'b0;

    // Top-of-memory fill
    lat = 3;
    i_list.push_back('{1'b0, 1'b0, 16'hFFFA, 16'h0});
    run_round();
    chk("top_done_lat", i_dn - i_start, BW + 3);

    // Reset after three I-side words; five responses still in flight
    lat = 6;
    push_exp('{1'b0, 1'b0, 16'h1000, 16'h0});
    last_m = 1'b0;
    repeat (2) @(negedge clk);
    i_addr = 16'h1000; i_req = 1'b1;
    rx0 = n_rx;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      if (n_rx - rx0 >= 3) break;
    end
    chk("words_before_reset", n_rx - rx0, 3);
    mv0 = mv_cnt;
    do_reset();
    repeat (10) @(negedge clk);
    chk("inflight_pulses", mv_cnt - mv0, 5);
    d_list.push_back('{1'b1, 1'b0, 16'h3004, 16'h0});
    run_round();

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      lat = $urandom_range(1, 6);
      ni = $urandom_range(0, 2);
      nd = $urandom_range(0, 2);
      if (ni + nd == 0) ni = 1;
      single_wr = 1'b0;
      for (int k = 0; k < ni; k++) begin
        t.is_d = 1'b0; t.wr = 1'b0; t.addr = 16'($urandom); t.wd = 16'h0;
        i_list.push_back(t);
      end
      for (int k = 0; k < nd; k++) begin
        t.is_d = 1'b1; t.wr = 1'($urandom_range(0, 1)); t.addr = 16'($urandom); t.wd = 16'($urandom);
        single_wr = t.wr;
        d_list.push_back(t);
      end
      run_round();
      if (ni + nd == 1)
        chk("single_latency", (ni == 1) ? (i_dn - i_start) : (d_dn - d_start),
            single_wr ? 1 : BW + lat);
    end

    repeat (4) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("issue_queue_empty", iss_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
